// File: rtl/red_pitaya_acq_pkg.sv
`default_nettype none
// ============================================================================
// red_pitaya_acq_pkg : shared FSM encoding, trigger source codes, averaging setup
// Revision 1.0
// ============================================================================
package red_pitaya_acq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } acq_state_t;

  localparam logic [2:0] SRC_NONE  = 3'd0;
  localparam logic [2:0] SRC_SW    = 3'd1;
  localparam logic [2:0] SRC_CH_P  = 3'd2;
  localparam logic [2:0] SRC_CH_N  = 3'd3;
  localparam logic [2:0] SRC_EXT_P = 3'd4;
  localparam logic [2:0] SRC_EXT_N = 3'd5;

  localparam logic [16:0] DEC_1   = 17'd1;
  localparam logic [16:0] DEC_8   = 17'd8;
  localparam logic [16:0] DEC_64  = 17'd64;
  localparam logic [16:0] DEC_1K  = 17'd1024;
  localparam logic [16:0] DEC_8K  = 17'd8192;
  localparam logic [16:0] DEC_64K = 17'd65536;

  // {averaging allowed, shift amount} for a given effective decimation
  function automatic logic [5:0] avg_shift(input logic [16:0] dec);
    case (dec)
      DEC_1:   return {1'b1, 5'd0};
      DEC_8:   return {1'b1, 5'd3};
      DEC_64:  return {1'b1, 5'd6};
      DEC_1K:  return {1'b1, 5'd10};
      DEC_8K:  return {1'b1, 5'd13};
      DEC_64K: return {1'b1, 5'd16};
      default: return 6'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/red_pitaya_acq_trig.sv
`default_nettype none
// ============================================================================
// red_pitaya_acq_trig : level crossing detector with hysteresis re-arm
// Revision 1.0
// ============================================================================
module red_pitaya_acq_trig (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] dat,
  input  logic [13:0] lvl,
  input  logic [13:0] hyst,
  output logic        trig_p,
  output logic        trig_n
);

  logic signed [14:0] dat_s;
  logic signed [14:0] lvl_s;
  logic signed [14:0] hyst_s;
  logic signed [14:0] lo_s;
  logic signed [14:0] hi_s;
  logic               rdy_p;
  logic               rdy_n;

  assign dat_s  = $signed({dat[13], dat});
  assign lvl_s  = $signed({lvl[13], lvl});
  assign hyst_s = $signed({1'b0, hyst});
  assign lo_s   = lvl_s - hyst_s;
  assign hi_s   = lvl_s + hyst_s;

  assign trig_p = rdy_p && (dat_s >= lvl_s);
  assign trig_n = rdy_n && (dat_s <= lvl_s);

  // A fire consumes the re-arm flag; it must be re-armed past the hysteresis band
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_p <= 1'b0;
      rdy_n <= 1'b0;
    end else begin
      if (trig_p)              rdy_p <= 1'b0;
      else if (dat_s <= lo_s)  rdy_p <= 1'b1;
      if (trig_n)              rdy_n <= 1'b0;
      else if (dat_s >= hi_s)  rdy_n <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/red_pitaya_acq_ch.sv
`default_nettype none
// ============================================================================
// red_pitaya_acq_ch : one acquisition channel (decimate, trigger, ring buffer)
// Revision 1.0
// ============================================================================
module red_pitaya_acq_ch
  import red_pitaya_acq_pkg::*;
#(
  parameter int RSZ = 14
) (
  input  logic           adc_clk_i,
  input  logic           adc_rst_i,
  input  logic [13:0]    adc_dat_i,
  input  logic           trig_sw_i,
  input  logic           trig_ext_i,
  input  logic [2:0]     trig_src_i,
  input  logic           set_arm_i,
  input  logic           set_rst_i,
  input  logic [16:0]    set_dec_i,
  input  logic           set_avg_i,
  input  logic [13:0]    set_lvl_i,
  input  logic [13:0]    set_hyst_i,
  input  logic [31:0]    set_dly_i,
  input  logic [RSZ-1:0] buf_addr_i,
  output logic [13:0]    buf_rdata_o,
  output logic [RSZ-1:0] wr_ptr_o,
  output logic [RSZ-1:0] trig_ptr_o,
  output logic           armed_o,
  output logic           trig_done_o,
  output logic           acq_done_o
);

  acq_state_t         state;
  logic [16:0]        dec_eff;
  logic [16:0]        dec_cnt;
  logic signed [30:0] acc;
  logic signed [30:0] win_sum;
  logic [5:0]         avg_cfg;
  logic [13:0]        smp;
  logic               smp_valid;
  logic               ch_p;
  logic               ch_n;
  logic               ext_q;
  logic               trig_evt;
  logic               arm_go;
  logic               trig_acc;
  logic               wr_en;
  logic [31:0]        post_cnt;
  logic [13:0]        mem [0:(1<<RSZ)-1];

  red_pitaya_acq_trig u_trig (
    .clk    (adc_clk_i),
    .rst    (adc_rst_i),
    .dat    (adc_dat_i),
    .lvl    (set_lvl_i),
    .hyst   (set_hyst_i),
    .trig_p (ch_p),
    .trig_n (ch_n)
  );

  assign dec_eff   = (set_dec_i == 17'd0) ? 17'd1 : set_dec_i;
  assign smp_valid = (dec_cnt >= dec_eff - 17'd1);
  assign win_sum   = acc + $signed({{17{adc_dat_i[13]}}, adc_dat_i});
  assign avg_cfg   = avg_shift(dec_eff);
  assign smp       = (set_avg_i && avg_cfg[5]) ? 14'(win_sum >>> avg_cfg[4:0]) : adc_dat_i;

  always_comb begin
    trig_evt = 1'b0;
    case (trig_src_i)
      SRC_SW:    trig_evt = trig_sw_i;
      SRC_CH_P:  trig_evt = ch_p;
      SRC_CH_N:  trig_evt = ch_n;
      SRC_EXT_P: trig_evt = trig_ext_i && !ext_q;
      SRC_EXT_N: trig_evt = !trig_ext_i && ext_q;
      default:   trig_evt = 1'b0;
    endcase
  end

  assign arm_go   = set_arm_i && !set_rst_i && ((state == ST_IDLE) || (state == ST_DONE));
  assign trig_acc = trig_evt && (state == ST_ARMED) && !set_arm_i && !set_rst_i;
  // The trigger-cycle sample is held back so trig_ptr marks the first POST write
  assign wr_en    = smp_valid && !set_rst_i &&
                    (((state == ST_ARMED) && !trig_acc) ||
                     ((state == ST_POST) && (post_cnt != 32'd0)));

  assign armed_o    = (state == ST_ARMED);
  assign acq_done_o = (state == ST_DONE);

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      state       <= ST_IDLE;
      wr_ptr_o    <= '0;
      trig_ptr_o  <= '0;
      post_cnt    <= 32'd0;
      trig_done_o <= 1'b0;
      dec_cnt     <= 17'd0;
      acc         <= '0;
      ext_q       <= 1'b0;
    end else begin
      ext_q       <= trig_ext_i;
      trig_done_o <= trig_acc;
      if (arm_go || smp_valid) begin
        dec_cnt <= 17'd0;
        acc     <= '0;
      end else begin
        dec_cnt <= dec_cnt + 17'd1;
        acc     <= win_sum;
      end
      if (wr_en) wr_ptr_o <= wr_ptr_o + 1'b1;
      if (set_rst_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: if (set_arm_i) state <= ST_ARMED;
          ST_ARMED: begin
            if (trig_acc) begin
              state      <= ST_POST;
              trig_ptr_o <= wr_ptr_o;
              post_cnt   <= set_dly_i;
            end
          end
          ST_POST: begin
            if (post_cnt == 32'd0) begin
              state <= ST_DONE;
            end else if (wr_en) begin
              post_cnt <= post_cnt - 32'd1;
              if (post_cnt == 32'd1) state <= ST_DONE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Read-before-write: a same-address write returns the previous contents
  always_ff @(posedge adc_clk_i) begin
    if (wr_en) mem[wr_ptr_o] <= smp;
    buf_rdata_o <= mem[buf_addr_i];
  end

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_acq_ch.sv
`default_nettype none
// ============================================================================
// tb_red_pitaya_acq_ch : randomized bench against a behavioural channel model
// Revision 1.0
// ============================================================================
module tb_red_pitaya_acq_ch;

  localparam int RSZ   = 7;
  localparam int DEPTH = 1 << RSZ;

  logic           clk = 1'b0;
  logic           adc_rst = 1'b1;
  logic [13:0]    adc_dat = '0;
  logic           trig_sw = 1'b0;
  logic           trig_ext = 1'b0;
  logic [2:0]     trig_src = '0;
  logic           set_arm = 1'b0;
  logic           set_rst = 1'b0;
  logic [16:0]    set_dec = 17'd1;
  logic           set_avg = 1'b0;
  logic [13:0]    set_lvl = '0;
  logic [13:0]    set_hyst = '0;
  logic [31:0]    set_dly = '0;
  logic [RSZ-1:0] buf_addr = '0;
  logic [13:0]    buf_rdata;
  logic [RSZ-1:0] wr_ptr;
  logic [RSZ-1:0] trig_ptr;
  logic           armed;
  logic           trig_done;
  logic           acq_done;

  always #5 clk = ~clk;

  red_pitaya_acq_ch #(.RSZ(RSZ)) dut (
    .adc_clk_i   (clk),
    .adc_rst_i   (adc_rst),
    .adc_dat_i   (adc_dat),
    .trig_sw_i   (trig_sw),
    .trig_ext_i  (trig_ext),
    .trig_src_i  (trig_src),
    .set_arm_i   (set_arm),
    .set_rst_i   (set_rst),
    .set_dec_i   (set_dec),
    .set_avg_i   (set_avg),
    .set_lvl_i   (set_lvl),
    .set_hyst_i  (set_hyst),
    .set_dly_i   (set_dly),
    .buf_addr_i  (buf_addr),
    .buf_rdata_o (buf_rdata),
    .wr_ptr_o    (wr_ptr),
    .trig_ptr_o  (trig_ptr),
    .armed_o     (armed),
    .trig_done_o (trig_done),
    .acq_done_o  (acq_done)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Behavioural model: mode 0 idle, 1 waiting for trigger, 2 post-trigger, 3 done
  int          m_mode, m_wr, m_tp, m_n;
  longint      m_rem, m_sum;
  bit          m_tdone, m_rp, m_rn, m_ext;
  logic [13:0] m_mem [DEPTH];
  bit          m_wrt [DEPTH];
  bit          rd_fixed = 1'b0;

  task automatic step();
    int x, l, h, dec;
    longint ws, qq;
    bit valid, trig, fr, ff, arm_ok, avg_ok, rd_known;
    logic [13:0] val, rd_exp;
    if (!rd_fixed)
      buf_addr = ($urandom_range(3) == 0) ? RSZ'(m_wr) : RSZ'($urandom_range(DEPTH - 1));
    rd_known = m_wrt[buf_addr];
    rd_exp   = m_mem[buf_addr];
    m_tdone  = 1'b0;
    if (adc_rst) begin
      m_mode = 0; m_wr = 0; m_tp = 0; m_rem = 0; m_sum = 0; m_n = 0;
      m_rp = 0; m_rn = 0; m_ext = 0;
    end else begin
      x   = int'($signed(adc_dat));
      l   = int'($signed(set_lvl));
      h   = int'(set_hyst);
      dec = (set_dec == 17'd0) ? 1 : int'(set_dec);
      fr  = m_rp && (x >= l);
      ff  = m_rn && (x <= l);
      case (trig_src)
        3'd1:    trig = trig_sw;
        3'd2:    trig = fr;
        3'd3:    trig = ff;
        3'd4:    trig = trig_ext && !m_ext;
        3'd5:    trig = !trig_ext && m_ext;
        default: trig = 1'b0;
      endcase
      ws     = m_sum + x;
      valid  = (m_n + 1 >= dec);
      avg_ok = set_avg && (dec inside {1, 8, 64, 1024, 8192, 65536});
      if (avg_ok) begin
        qq = ws / dec;
        if (ws < 0 && qq * dec != ws) qq--;
        val = qq[13:0];
      end else begin
        val = adc_dat;
      end
      arm_ok = !set_rst && set_arm && (m_mode == 0 || m_mode == 3);
      if (set_rst) m_mode = 0;
      else begin
        case (m_mode)
          0, 3: if (set_arm) m_mode = 1;
          1: begin
            if (trig && !set_arm) begin
              m_tp = m_wr; m_rem = set_dly; m_mode = 2; m_tdone = 1'b1;
            end else if (valid) begin
              m_mem[m_wr] = val; m_wrt[m_wr] = 1'b1; m_wr = (m_wr + 1) % DEPTH;
            end
          end
          default: begin
            if (m_rem == 0) m_mode = 3;
            else if (valid) begin
              m_mem[m_wr] = val; m_wrt[m_wr] = 1'b1; m_wr = (m_wr + 1) % DEPTH;
              m_rem--;
              if (m_rem == 0) m_mode = 3;
            end
          end
        endcase
      end
      if (fr) m_rp = 0; else if (x <= l - h) m_rp = 1;
      if (ff) m_rn = 0; else if (x >= l + h) m_rn = 1;
      m_ext = trig_ext;
      if (arm_ok || valid) begin m_sum = 0; m_n = 0; end
      else begin m_sum = ws; m_n++; end
    end
    @(posedge clk); #1;
    check("wr_ptr", wr_ptr, m_wr);
    check("trig_ptr", trig_ptr, m_tp);
    check("armed", armed, m_mode == 1);
    check("trig_done", trig_done, m_tdone);
    check("acq_done", acq_done, m_mode == 3);
    if (rd_known) check("rdata", buf_rdata, rd_exp);
  endtask

  task automatic rand_dat();
    int v;
    v = int'($urandom_range(16383)) - 8192;
    adc_dat = v[13:0];
  endtask

  task automatic do_reset();
    adc_rst = 1'b1; step(); adc_rst = 1'b0;
  endtask

  task automatic arm();
    set_arm = 1'b1; step(); set_arm = 1'b0;
  endtask

  initial begin
    int cnt, v, w0;
    foreach (m_wrt[i]) m_wrt[i] = 1'b0;
    step(); step();
    adc_rst = 1'b0;
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_trig_ptr", trig_ptr, 0);
    check("rst_flags", {armed, trig_done, acq_done}, 0);

    // Software trigger at write address 100, ten post samples
    set_dec = 17'd1; trig_src = 3'd1; set_dly = 32'd10;
    arm();
    for (int i = 0; i < 300 && m_wr != 100; i++) begin rand_dat(); step(); end
    check("sw_reach_100", wr_ptr, 100);
    trig_sw = 1'b1; rand_dat(); step(); trig_sw = 1'b0;
    repeat (15) begin rand_dat(); step(); end
    check("sw_trig_ptr", trig_ptr, 100);
    check("sw_wr_ptr", wr_ptr, 110);
    check("sw_done", acq_done, 1);

    // Rising channel trigger with hysteresis, then noise around the level
    adc_dat = 14'h3F9C;
    do_reset();
    trig_src = 3'd2; set_lvl = 14'd0; set_hyst = 14'd50; set_dly = 32'd1000;
    arm();
    cnt = 0;
    for (int i = -100; i <= 100; i++) begin
      v = i; adc_dat = v[13:0]; step();
      if (trig_done) begin
        cnt++;
        check("ch_first_ge0", i, 0);
      end
    end
    repeat (100) begin
      v = int'($urandom_range(40)) - 20; adc_dat = v[13:0]; step();
      cnt += int'(trig_done);
    end
    check("ch_single_trig", cnt, 1);

    // Averaging over 8 with a constant input, then plain decimation of a ramp
    do_reset();
    trig_src = 3'd0; set_dec = 17'd8; set_avg = 1'b1; adc_dat = 14'd1000;
    arm();
    repeat (80) step();
    rd_fixed = 1'b1;
    for (int k = 0; k < 10; k++) begin
      buf_addr = RSZ'(k); step();
      check("avg_const", buf_rdata, 1000);
    end
    rd_fixed = 1'b0;
    do_reset();
    set_avg = 1'b0;
    arm();
    for (int i = 0; i < 80; i++) begin v = 3 * i - 50; adc_dat = v[13:0]; step(); end
    rd_fixed = 1'b1;
    buf_addr = RSZ'(2); step();
    check("dec_ramp_addr2", buf_rdata, 19);
    rd_fixed = 1'b0;

    // Pointer wrap before the trigger, then abort mid-capture
    do_reset();
    set_dec = 17'd1; trig_src = 3'd1; set_dly = 32'd50;
    arm();
    repeat (DEPTH + 5) begin rand_dat(); step(); end
    check("wrap_wr_ptr", wr_ptr, 5);
    trig_sw = 1'b1; step(); trig_sw = 1'b0;
    check("wrap_trig_ptr", trig_ptr, 5);
    repeat (5) begin rand_dat(); step(); end
    set_rst = 1'b1; step(); set_rst = 1'b0;
    w0 = int'(wr_ptr);
    check("abort_idle", {armed, acq_done}, 0);
    repeat (5) begin rand_dat(); step(); end
    check("abort_hold", wr_ptr, w0);
    set_arm = 1'b1; trig_sw = 1'b1; step(); set_arm = 1'b0; trig_sw = 1'b0;
    check("arm_trig_ignored", trig_done, 0);
    check("arm_state", armed, 1);

    // Randomized configurations and control traffic
    repeat (25) begin
      case ($urandom_range(4))
        0: set_dec = 17'd0;
        1: set_dec = 17'd1;
        2: set_dec = 17'd3;
        3: set_dec = 17'd8;
        default: set_dec = 17'd2;
      endcase
      set_avg  = 1'($urandom_range(1));
      trig_src = 3'($urandom_range(5));
      set_dly  = 32'($urandom_range(20));
      v = int'($urandom_range(400)) - 200; set_lvl = v[13:0];
      set_hyst = 14'($urandom_range(100));
      if ($urandom_range(4) == 0) do_reset();
      arm();
      repeat (60) begin
        if ($urandom_range(3) == 0) rand_dat();
        else begin v = int'($urandom_range(800)) - 400; adc_dat = v[13:0]; end
        trig_sw = ($urandom_range(15) == 0);
        if ($urandom_range(5) == 0) trig_ext = ~trig_ext;
        set_arm = ($urandom_range(19) == 0);
        set_rst = ($urandom_range(49) == 0);
        step();
      end
      trig_sw = 1'b0; set_arm = 1'b0; set_rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/red_pitaya_acq_ch.md
RED_PITAYA_ACQ_CH -- requirements
Module: red_pitaya_acq_ch

Interface
REQ-001 SHALL have parameter RSZ, default 14, meaning log2 of buffer depth in samples.
REQ-002 SHALL have ports (name direction width meaning), with clock and reset first:
- adc_clk_i  in  1  the single clock for all logic.
- adc_rst_i  in  1  reset, synchronous, active-high.
- adc_dat_i  in  14  signed ADC sample, valid every cycle.
- trig_sw_i  in  1  software trigger pulse.
- trig_ext_i  in  1  external trigger, already synchronized.
- trig_src_i  in  3  source select: 0 none, 1 sw, 2 ch rising, 3 ch falling, 4 ext rising, 5 ext falling.
- set_arm_i  in  1  arm pulse.
- set_rst_i  in  1  abort to IDLE.
- set_dec_i  in  17  decimation factor; 0 is treated as 1.
- set_avg_i  in  1  average over the decimation window.
- set_lvl_i  in  14  signed trigger level.
- set_hyst_i  in  14  unsigned hysteresis.
- set_dly_i  in  32  post-trigger decimated samples.
- buf_addr_i  in  RSZ  read-back address.
- buf_rdata_o  out  14  read-back data.
- wr_ptr_o  out  RSZ  next write address.
- trig_ptr_o  out  RSZ  write address of the first post-trigger sample.
- armed_o  out  1  high while in ARMED.
- trig_done_o  out  1  one-cycle pulse on accepted trigger.
- acq_done_o  out  1  high while in DONE.

Function
REQ-003 SHALL implement FSM IDLE -> ARMED on set_arm_i; ARMED -> POST on accepted trigger; POST -> DONE when post counter expires; DONE -> ARMED on set_arm_i; any state -> IDLE on set_rst_i (dominates all other inputs).
REQ-004 SHALL generate sample-valid once per set_dec_i cycles from a decimation counter that restarts to 0 on the arming cycle.
REQ-005 With set_avg_i=1 and set_dec_i in {1,8,64,1024,8192,65536}, the written sample SHALL be the signed window sum arithmetically shifted right by log2(set_dec_i) (sum width 31 bits); otherwise the written sample SHALL be the last raw sample of the window.
REQ-006 In ARMED and POST, each valid sample SHALL be written to buf[wr_ptr] and wr_ptr SHALL increment, wrapping from 2^RSZ-1 to 0.
REQ-007 Channel trigger SHALL re-arm when the sample is at or below lvl-hyst (rising) or at or above lvl+hyst (falling), and SHALL fire on the first sample at or above lvl (rising) or at or below lvl (falling) after re-arming, using signed 15-bit compares.
REQ-008 External trigger SHALL be edge-detected on trig_ext_i with one register stage.
REQ-009 Triggers SHALL be accepted only in ARMED and never on the cycle of set_arm_i; all others are ignored.
REQ-010 On an accepted trigger: trig_ptr_o <= wr_ptr; post counter <= set_dly_i; trig_done_o pulses for 1 cycle.
REQ-011 In POST, the counter SHALL decrement per written sample, and the FSM SHALL enter DONE on the write that takes it to 0.
REQ-012 set_dly_i=0 SHALL go to DONE on the cycle after the trigger with no further writes.
REQ-013 In IDLE and DONE, no writes SHALL occur and wr_ptr SHALL hold.
REQ-014 Read-back SHALL have 1-cycle latency; on a same-cycle same-address write, it SHALL return the old data.

Reset
REQ-015 adc_rst_i SHALL force IDLE, wr_ptr_o=0, trig_ptr_o=0, armed_o=0, trig_done_o=0, acq_done_o=0, and clear all counters and the hysteresis flags; buffer contents are not reset; buf_rdata_o is unspecified until the first read.

Structure
REQ-016 The shared package SHALL hold the FSM state encoding, the trig_src_i codes and the averaging-capable decimation constants.
REQ-017 Level/hysteresis crossing SHALL be a sub-module, red_pitaya_acq_trig, with outputs trig_p and trig_n.

Verification
REQ-018 Arm, dec=1, src=1, dly=10, sw trigger at wr_ptr=100 -> trig_ptr_o=100, exactly 10 more writes, acq_done_o=1, wr_ptr_o=110.
REQ-019 src=2, lvl=0, hyst=50, ramp from -100 to 100 -> a single trig_done_o at the first sample >=0; noise of ±20 around 0 afterwards -> no retrigger.
REQ-020 dec=8, avg=1, constant input 1000 -> stored 1000; dec=8, avg=0, ramp -> every 8th sample stored.
REQ-021 Arm, 2^RSZ+5 samples, then trigger -> wr_ptr wraps and trig_ptr_o=5.
REQ-022 set_rst_i mid-POST -> IDLE next cycle, writes stop; set_arm_i with a sw trigger in the same cycle -> trigger ignored.
